// File: rtl/display_scan_if.sv
// Bundles the scan controller's control inputs and display outputs.
// The master side drives value/control, the slave side is the scanner.
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    lz_suppress;
    logic [3:0]              bcd_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output enable, load, value_in, lz_suppress,
        input  bcd_out, digit_en, frame_done, pending
    );

    modport slave (
        input  enable, load, value_in, lz_suppress,
        output bcd_out, digit_en, frame_done, pending
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with tear-free value updates,
// a per-slot blanking guard and optional leading-zero suppression.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    display_scan_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] activeVal_q, activeVal_d;
    logic [4*NUM_DIGITS-1:0] pendVal_q, pendVal_d;
    logic                    pending_q, pending_d;
    logic                    frameStart;

    logic [3:0]              bcdOut_q, bcdOut_d;
    logic [NUM_DIGITS-1:0]   digitEn_q, digitEn_d;
    logic                    frameDone_q, frameDone_d;
    logic [NUM_DIGITS-1:0]   suppress;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            activeVal_q <= '0;
            pendVal_q   <= '0;
            pending_q   <= 1'b0;
            bcdOut_q    <= '0;
            digitEn_q   <= '0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            activeVal_q <= activeVal_d;
            pendVal_q   <= pendVal_d;
            pending_q   <= pending_d;
            bcdOut_q    <= bcdOut_d;
            digitEn_q   <= digitEn_d;
            frameDone_q <= frameDone_d;
        end
    end

    // Pending value is swapped in only when a new frame begins at index 0,
    // so a single frame never mixes digits from two different values.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        activeVal_d = activeVal_q;
        pendVal_d   = pendVal_q;
        pending_d   = pending_q;
        frameStart  = 1'b0;

        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                    idx_d      = '0;
                    cnt_d      = '0;
                    frameStart = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = SHOW;
                end
                SHOW: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
                        if (idx_q == LAST_IDX) begin
                            idx_d      = '0;
                            frameStart = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (frameStart && pending_q) begin
            activeVal_d = pendVal_q;
            pending_d   = 1'b0;
        end
        if (bus.load) begin
            pendVal_d = bus.value_in;
            pending_d = 1'b1;
        end
    end

    // Outputs are computed from next state so they line up with the state
    // register; suppression uses the value that will be active next cycle.
    always_comb begin
        logic upperZero;
        suppress    = '0;
        upperZero   = 1'b1;
        bcdOut_d    = '0;
        digitEn_d   = '0;
        frameDone_d = 1'b0;

        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upperZero   = upperZero && (activeVal_d[4*k +: 4] == 4'd0);
            suppress[k] = bus.lz_suppress && upperZero;
        end

        if (state_d != IDLE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_d == IW'(k)) begin
                    bcdOut_d = activeVal_d[4*k +: 4];
                    if (state_d == SHOW && !suppress[k]) digitEn_d[k] = 1'b1;
                end
            end
        end

        frameDone_d = (state_d == SHOW) && (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
    end

    assign bus.bcd_out    = bcdOut_q;
    assign bus.digit_en   = digitEn_q;
    assign bus.frame_done = frameDone_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with hand-computed expectations per slot.
module tb_display_scan_ctrl;
    localparam int NUM_DIGITS   = 4;
    localparam int SLOT_CYCLES  = 8;
    localparam int BLANK_CYCLES = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    display_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'd0: seg7 = 7'b1111110;
            4'd1: seg7 = 7'b0110000;
            4'd2: seg7 = 7'b1101101;
            4'd3: seg7 = 7'b1111001;
            4'd4: seg7 = 7'b0110011;
            4'd5: seg7 = 7'b1011011;
            4'd6: seg7 = 7'b1011111;
            4'd7: seg7 = 7'b1110000;
            4'd8: seg7 = 7'b1111111;
            4'd9: seg7 = 7'b1111011;
            default: seg7 = 7'b1001111;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] value);
        bus.load     = 1'b1;
        bus.value_in = value;
        tick();
        bus.load     = 1'b0;
    endtask

    // One digit slot: BLANK cycles show the nibble with no strobe, then SHOW strobes expEn.
    task automatic checkSlot(input logic [3:0] expBcd, input logic [3:0] expEn, input bit lastSlot,
                             input int nCycles, input int loadAt, input logic [15:0] loadVal);
        for (int j = 0; j < nCycles; j++) begin
            if (j == loadAt) begin
                bus.load     = 1'b1;
                bus.value_in = loadVal;
            end
            tick();
            bus.load = 1'b0;
            checkOutput("bcd_out", 16'(bus.bcd_out), 16'(expBcd));
            checkOutput("digit_en", 16'(bus.digit_en), (j < BLANK_CYCLES) ? 16'h0 : 16'(expEn));
            checkOutput("frame_done", 16'(bus.frame_done), 16'(lastSlot && j == SLOT_CYCLES - 1));
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_bcd"}, 16'(bus.bcd_out), 16'h0);
        checkOutput({tag, "_en"}, 16'(bus.digit_en), 16'h0);
        checkOutput({tag, "_fd"}, 16'(bus.frame_done), 16'h0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.value_in    = '0;
        bus.lz_suppress = 1'b0;
        tick();
        tick();
        checkIdleOutputs("reset");
        checkOutput("reset_pending", 16'(bus.pending), 16'h0);
        rst = 1'b0;

        $display("[TB] basic scan of 1234");
        applyStimulus(16'h1234);
        checkOutput("pending_after_load", 16'(bus.pending), 16'h1);
        checkIdleOutputs("idle_before_enable");
        bus.enable = 1'b1;
        checkSlot(4'h4, 4'b0001, 0, 8, -1, 16'h0);
        checkOutput("pending_after_transfer", 16'(bus.pending), 16'h0);
        checkSlot(4'h3, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h2, 4'b0100, 0, 8, -1, 16'h0);
        checkSlot(4'h1, 4'b1000, 1, 8, -1, 16'h0);

        $display("[TB] tear-free update to 5678");
        checkSlot(4'h4, 4'b0001, 0, 8, -1, 16'h0);
        checkSlot(4'h3, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h2, 4'b0100, 0, 8, 3, 16'h5678);
        checkOutput("pending_mid_frame", 16'(bus.pending), 16'h1);
        checkSlot(4'h1, 4'b1000, 1, 8, -1, 16'h0);
        checkOutput("pending_end_frame", 16'(bus.pending), 16'h1);
        checkSlot(4'h8, 4'b0001, 0, 8, -1, 16'h0);
        checkOutput("pending_new_frame", 16'(bus.pending), 16'h0);
        bus.lz_suppress = 1'b1;
        checkSlot(4'h7, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h6, 4'b0100, 0, 8, -1, 16'h0);
        checkSlot(4'h5, 4'b1000, 1, 8, 2, 16'h0040);

        $display("[TB] leading-zero suppression");
        checkSlot(4'h0, 4'b0001, 0, 8, -1, 16'h0);
        checkSlot(4'h4, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0000, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0000, 1, 8, 2, 16'h0000);
        checkSlot(4'h0, 4'b0001, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0000, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0000, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0000, 1, 8, -1, 16'h0);
        bus.lz_suppress = 1'b0;
        checkSlot(4'h0, 4'b0001, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0100, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b1000, 1, 8, 2, 16'h00A9);

        $display("[TB] invalid code passthrough");
        checkSlot(4'h9, 4'b0001, 0, 8, -1, 16'h0);
        checkSlot(4'hA, 4'b0010, 0, 8, -1, 16'h0);
        checkOutput("seg_invalid", 16'(seg7(bus.bcd_out)), 16'(7'b1001111));
        checkSlot(4'h0, 4'b0100, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b1000, 1, 8, -1, 16'h0);

        $display("[TB] abort by enable");
        checkSlot(4'h9, 4'b0001, 0, 8, -1, 16'h0);
        checkSlot(4'hA, 4'b0010, 0, 4, -1, 16'h0);
        bus.enable = 1'b0;
        tick();
        checkIdleOutputs("abort");
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("abort_no_frame_done", 16'(bus.frame_done), 16'h0);
        end
        bus.enable = 1'b1;
        checkSlot(4'h9, 4'b0001, 0, 8, -1, 16'h0);

        $display("[TB] reset mid-show");
        checkSlot(4'hA, 4'b0010, 0, 5, -1, 16'h0);
        rst = 1'b1;
        tick();
        checkIdleOutputs("mid_reset");
        checkOutput("mid_reset_pending", 16'(bus.pending), 16'h0);
        rst = 1'b0;
        checkSlot(4'h0, 4'b0001, 0, 8, -1, 16'h0);
        checkOutput("pending_after_reset", 16'(bus.pending), 16'h0);
        checkSlot(4'h0, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h0, 4'b0100, 0, 8, 3, 16'h2222);
        checkSlot(4'h0, 4'b1000, 1, 8, -1, 16'h0);
        checkOutput("pending_2222", 16'(bus.pending), 16'h1);

        $display("[TB] load on frame wrap");
        checkSlot(4'h2, 4'b0001, 0, 8, 0, 16'h1111);
        checkOutput("pending_after_wrap_load", 16'(bus.pending), 16'h1);
        checkSlot(4'h2, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h2, 4'b0100, 0, 8, -1, 16'h0);
        checkSlot(4'h2, 4'b1000, 1, 8, -1, 16'h0);
        checkSlot(4'h1, 4'b0001, 0, 8, -1, 16'h0);
        checkOutput("pending_1111_taken", 16'(bus.pending), 16'h0);
        checkSlot(4'h1, 4'b0010, 0, 8, -1, 16'h0);
        checkSlot(4'h1, 4'b0100, 0, 8, -1, 16'h0);
        checkSlot(4'h1, 4'b1000, 1, 8, -1, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of NUM_DIGITS common-strobed 7-segment digits.
- Holds a packed BCD value and steps through the digits one at a time. Each slot presents one nibble on bcd_out, which feeds the team's BCD-to-segment decoder (a..g, active-high; non-decimal codes decode to the "E" pattern). The matching one-hot digit_en strobe is asserted alongside it.
- Adds tear-free value updates, an anti-ghosting blank window per slot, and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; range 2..8.
- SLOT_CYCLES, 50000, clock cycles each digit owns per frame; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 2, cycles at the start of each slot with all digit_en low (ghosting guard); may be 0.

Ports:
- clk, in, 1, system clock; all logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, scan run; when 0 the scanner parks.
- load, in, 1, single-cycle strobe that captures value_in into the pending register.
- value_in, in, 4*NUM_DIGITS, packed BCD; nibble 0 (bits 3:0) is the least-significant digit.
- lz_suppress, in, 1, blank leading zero digits when 1.
- bcd_out, out, 4, nibble for the current slot, routed to the segment decoder.
- digit_en, out, NUM_DIGITS, one-hot digit strobe, active-high.
- frame_done, out, 1, one-cycle pulse at the end of the last slot of each frame.
- pending, out, 1, high from a load until that value becomes active.

Behaviour:
- Reset values: bcd_out=0, digit_en=0, frame_done=0, pending=0. Active and pending registers cleared to 0. State IDLE, digit index 0, slot counter 0.
- Reset mid-frame takes effect on the next edge and overrides every other input.
- FSM states:
  - IDLE: outputs are reset values. Move to BLANK with index 0 when enable=1.
  - BLANK: lasts BLANK_CYCLES cycles, then goes to SHOW. If BLANK_CYCLES=0, go straight to SHOW.
  - SHOW: lasts SLOT_CYCLES-BLANK_CYCLES cycles. At the end, index wraps (NUM_DIGITS-1 goes to 0, otherwise increments) and the FSM returns to BLANK.
- enable=0 in any state returns to IDLE on the next edge and clears index and counter. The active value is retained.
- Slot counter: counts 0..SLOT_CYCLES-1 and wraps at the end of each slot.
- Outputs are registered:
  - bcd_out equals the active nibble[index] for the whole slot, BLANK included.
  - digit_en has bit[index]=1 only in SHOW, and only for a digit that is not suppressed.
- Suppression: digit k is suppressed when lz_suppress=1, k>0, and active nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
  - Example: 0000 shows only digit 0, displaying "0".
- Suppression is evaluated from the active register and the live lz_suppress each cycle.
- Load and pending:
  - load=1 copies value_in to the pending register and sets pending=1.
  - A repeated load before the transfer overwrites the pending value (last one wins).
- Transfer to active: at the edge where the FSM enters index 0 (first slot of a frame, including from IDLE), if pending=1, pending moves to active and pending clears. This guarantees no frame mixes old and new digits.
- Load and transfer on the same edge: the new value_in goes to pending and pending stays 1. The transfer uses the previously pending value.
- Invalid nibbles (A..F) are passed through unchanged; the decoder renders them as "E".
- frame_done: pulses in the last SHOW cycle of index NUM_DIGITS-1. It does not fire when a frame is aborted by enable=0 or rst.
- Frame length is exactly NUM_DIGITS*SLOT_CYCLES cycles.

Test Plan:
- Basic scan: NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2. Reset, load 0x1234, enable.
  - digit_en sequence per slot is 0000 x2 then 0001 x6, then 0010, 0100, 1000.
  - bcd_out is 4, 3, 2, 1.
  - frame_done pulses every 32 cycles.
- Tear-free update: load 0x5678 during slot 2.
  - Slots 2 and 3 still show 2 and 1; pending=1.
  - Next frame shows 8, 7, 6, 5 and pending falls on entry to index 0.
- Leading zeros: load 0x0040 with lz_suppress=1.
  - Digits 0 and 1 strobe (bcd 0, 4); digits 2 and 3 never assert digit_en.
  - Load 0x0000: only digit 0 strobes.
  - With lz_suppress=0, all four strobe.
- Invalid code: load 0x00A9.
  - bcd_out shows 9 then 0xA on digit 1, which the decoder maps to 1001111.
- Abort and reset:
  - Drop enable mid-slot 1: next edge digit_en=0 and no frame_done. Re-enable: scan restarts at index 0 with BLANK.
  - Assert rst mid-SHOW: all outputs 0 and active=0 next cycle.
- Simultaneous events: load 0x1111 on the exact edge of the frame wrap while 0x2222 is pending.
  - Frame shows 2222; pending stays 1; the following frame shows 1111.
